// File: rtl/nubus_vram_fetch.sv
// Video fetch engine: walks the framebuffer through the VRAM arbiter's video port,
// one word per request, and stages the words in a first-word fall-through line FIFO.
module nubus_vram_fetch #(
    parameter int FIFO_DEPTH = 16,
    parameter int MIN_REQ    = 3
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic                            frame_start,
    input  logic [24:0]                     fb_base,
    input  logic [17:0]                     frame_words,
    output logic [24:0]                     vram_addr,
    output logic [15:0]                     vram_dout,
    output logic                            vram_rd,
    output logic                            vram_wr,
    input  logic [15:0]                     vram_din,
    input  logic                            vram_ready,
    input  logic                            pix_pop,
    output logic [15:0]                     pix_data,
    output logic                            pix_valid,
    output logic                            underflow,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int AW = (MIN_REQ < 2) ? 1 : $clog2(MIN_REQ + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Handshake: vram_rd is held with a stable vram_addr for the whole REQ state;
    // a word is taken on the first cycle vram_ready=1 once req_age has reached MIN_REQ.
    state_t          state_q, state_d;
    logic [24:0]     addr_q, addr_d;
    logic [17:0]     rem_q, rem_d;
    logic [AW-1:0]   age_q, age_d;
    logic            rd_q, rd_d;
    logic            underflow_q, underflow_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]   count_q, count_d;
    logic [15:0]     mem_q [FIFO_DEPTH];

    logic            accept;
    logic            push;
    logic            pop;

    assign accept = (state_q == REQ) && vram_ready && (age_q >= AW'(MIN_REQ));

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        age_d       = age_q;
        rd_d        = rd_q;
        underflow_d = underflow_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        push        = 1'b0;
        pop         = 1'b0;

        case (state_q)
            IDLE: begin
                // Only one request in flight, so a free slot now is a free slot at push time.
                if (enable && (rem_q != 18'd0) && (count_q < LW'(FIFO_DEPTH))) begin
                    state_d = REQ;
                    age_d   = AW'(1);
                    rd_d    = 1'b1;
                end
            end
            REQ: begin
                if (age_q < AW'(MIN_REQ)) begin
                    age_d = age_q + AW'(1);
                end
                if (accept) begin
                    state_d = GAP;
                    rd_d    = 1'b0;
                    push    = 1'b1;
                    addr_d  = addr_q + 25'd2;
                    rem_d   = rem_q - 18'd1;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                rd_d    = 1'b0;
            end
        endcase

        if (pix_pop) begin
            if (count_q != '0) begin
                pop = 1'b1;
            end else begin
                underflow_d = 1'b1;
            end
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + LW'(push) - LW'(pop);

        // A new frame abandons everything, including a word accepted this same cycle.
        if (frame_start) begin
            state_d     = GAP;
            rd_d        = 1'b0;
            addr_d      = fb_base & ~25'd1;
            rem_d       = frame_words;
            underflow_d = 1'b0;
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            count_d     = '0;
            push        = 1'b0;
            pop         = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            age_q       <= '0;
            rd_q        <= 1'b0;
            underflow_q <= 1'b0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            age_q       <= age_d;
            rd_q        <= rd_d;
            underflow_q <= underflow_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
        end
    end

    // Storage needs no reset: pix_data is gated by occupancy.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_q[wr_ptr_q] <= vram_din;
        end
    end

    assign vram_addr  = addr_q;
    assign vram_rd    = rd_q;
    assign vram_wr    = 1'b0;
    assign vram_dout  = 16'h0000;
    assign fifo_level = count_q;
    assign pix_valid  = (count_q != '0);
    assign pix_data   = pix_valid ? mem_q[rd_ptr_q] : 16'h0000;
    assign underflow  = underflow_q;

endmodule

// File: tb/tb_nubus_vram_fetch.sv
// Bench for nubus_vram_fetch: arbiter model, spec-level reference model checked
// every cycle, plus directed scenarios with hand-computed literals.
module tb_nubus_vram_fetch;

  localparam int DEPTH   = 16;
  localparam int MIN_REQ = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        frame_start = 1'b0;
  logic [24:0] fb_base = '0;
  logic [17:0] frame_words = '0;
  logic [24:0] vram_addr;
  logic [15:0] vram_dout;
  logic        vram_rd;
  logic        vram_wr;
  logic [15:0] vram_din = 16'hDEAD;
  logic        vram_ready = 1'b0;
  logic        pix_pop = 1'b0;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        underflow;
  logic [4:0]  fifo_level;

  int errors = 0;
  int checks = 0;

  nubus_vram_fetch #(.FIFO_DEPTH(DEPTH), .MIN_REQ(MIN_REQ)) dut (
    .clk(clk), .reset(reset), .enable(enable), .frame_start(frame_start),
    .fb_base(fb_base), .frame_words(frame_words), .vram_addr(vram_addr),
    .vram_dout(vram_dout), .vram_rd(vram_rd), .vram_wr(vram_wr),
    .vram_din(vram_din), .vram_ready(vram_ready), .pix_pop(pix_pop),
    .pix_data(pix_data), .pix_valid(pix_valid), .underflow(underflow),
    .fifo_level(fifo_level)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // arbiter: mode 0 answers arb_delay cycles into a request with address-derived
  // data; mode 1 holds ready high and returns 0xE000 + cycles-into-request.
  int arb_mode = 0;
  int arb_delay = 4;
  int rd_cnt = 0;
  always @(posedge clk) begin
    #1;
    rd_cnt = (vram_rd === 1'b1) ? rd_cnt + 1 : 0;
    if (arb_mode == 1) begin
      vram_ready = 1'b1;
      vram_din   = 16'hE000 + rd_cnt[15:0];
    end else begin
      vram_ready = (vram_rd === 1'b1) && (rd_cnt >= arb_delay);
      vram_din   = vram_ready ? (16'h5000 | {4'h0, vram_addr[12:1]}) : 16'hDEAD;
    end
  end

  // request monitor: addresses at each rising vram_rd
  logic [24:0] seen_addr[$];
  int rise_cnt = 0;
  logic prev_rd = 1'b0;
  always @(negedge clk) begin
    if (vram_rd === 1'b1 && prev_rd !== 1'b1) begin
      seen_addr.push_back(vram_addr);
      rise_cnt++;
    end
    prev_rd = vram_rd;
  end

  // reference model: phase 0 idle, 1 requesting, 2 one-cycle gap
  int          m_phase = 0;
  int          m_age = 0;
  logic [24:0] m_addr = '0;
  int          m_rem = 0;
  bit          m_uf = 1'b0;
  logic [15:0] exp_q[$];

  always @(negedge clk) begin
    int sz;
    bit do_push;
    logic [15:0] w;
    chk("vram_rd", vram_rd, m_phase == 1);
    chk("vram_addr", vram_addr, m_addr);
    chk("fifo_level", fifo_level, exp_q.size());
    chk("pix_valid", pix_valid, exp_q.size() != 0);
    chk("pix_data", pix_data, (exp_q.size() != 0) ? exp_q[0] : 16'h0000);
    chk("underflow", underflow, m_uf);
    chk("vram_wr", vram_wr, 0);
    chk("vram_dout", vram_dout, 0);
    chk("occupancy", (32'(fifo_level) + 32'(vram_rd)) <= DEPTH, 1);
    do_push = 1'b0;
    w = '0;
    sz = exp_q.size();
    if (reset) begin
      m_phase = 0; m_age = 0; m_addr = '0; m_rem = 0; m_uf = 1'b0;
      exp_q.delete();
    end else if (frame_start) begin
      exp_q.delete();
      m_addr  = fb_base & ~25'd1;
      m_rem   = int'(frame_words);
      m_uf    = 1'b0;
      m_phase = 2;
    end else begin
      if (m_phase == 0) begin
        if (enable && m_rem > 0 && sz < DEPTH) begin
          m_phase = 1;
          m_age   = 1;
        end
      end else if (m_phase == 1) begin
        if (vram_ready && m_age >= MIN_REQ) begin
          do_push = 1'b1;
          w       = vram_din;
          m_addr  = m_addr + 25'd2;
          m_rem   = m_rem - 1;
          m_phase = 2;
        end else if (m_age < MIN_REQ) begin
          m_age = m_age + 1;
        end
      end else begin
        m_phase = 0;
      end
      if (pix_pop) begin
        if (sz > 0) void'(exp_q.pop_front());
        else m_uf = 1'b1;
      end
      if (do_push) exp_q.push_back(w);
    end
  end

  // driver tasks
  task automatic pulse_frame(input logic [24:0] base, input logic [17:0] words);
    @(posedge clk); #1;
    fb_base = base; frame_words = words; frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic pop_expect(input logic [15:0] exp, input string name);
    @(posedge clk); #1;
    pix_pop = 1'b1;
    @(negedge clk);
    chk(name, pix_data, exp);
    @(posedge clk); #1;
    pix_pop = 1'b0;
  endtask

  task automatic wait_level(input int lvl, input int budget, input string name);
    int n = 0;
    @(negedge clk);
    while (int'(fifo_level) != lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, n < budget, 1);
  endtask

  task automatic wait_rd(input int budget, input string name);
    int n = 0;
    @(negedge clk);
    while (vram_rd !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, n < budget, 1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_rd", vram_rd, 0);
    chk("rst_addr", vram_addr, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_valid", pix_valid, 0);
    chk("rst_data", pix_data, 0);
    chk("rst_uf", underflow, 0);
    @(posedge clk); #1;
    enable = 1'b1;
    rise_cnt = 0;
    idle_cycles(8);
    chk("rst_no_req", rise_cnt, 0);

    // basic frame of four words, ready four cycles into each request
    arb_mode = 0; arb_delay = 4;
    seen_addr.delete();
    pulse_frame(25'h100, 18'd4);
    wait_level(4, 200, "basic_timeout");
    idle_cycles(4);
    chk("basic_nreq", seen_addr.size(), 4);
    chk("basic_a0", seen_addr[0], 25'h100);
    chk("basic_a1", seen_addr[1], 25'h102);
    chk("basic_a2", seen_addr[2], 25'h104);
    chk("basic_a3", seen_addr[3], 25'h106);
    @(negedge clk);
    chk("basic_idle_rd", vram_rd, 0);
    pop_expect(16'h5080, "basic_d0");
    pop_expect(16'h5081, "basic_d1");
    pop_expect(16'h5082, "basic_d2");
    pop_expect(16'h5083, "basic_d3");

    // ready held high from before the request: word taken on the third cycle
    arb_mode = 1;
    seen_addr.delete();
    pulse_frame(25'h400, 18'd1);
    wait_level(1, 100, "stale_timeout");
    chk("stale_addr", seen_addr[0], 25'h400);
    pop_expect(16'hE003, "stale_word");
    arb_mode = 0;

    // fill to depth, then one pop releases exactly one request
    arb_delay = 2;
    pulse_frame(25'h0, 18'd40);
    wait_level(16, 400, "fill_timeout");
    @(posedge clk); #1;
    rise_cnt = 0;
    idle_cycles(20);
    chk("fill_no_req", rise_cnt, 0);
    chk("fill_level", fifo_level, 16);
    seen_addr.delete();
    pop_expect(16'h5000, "fill_head");
    idle_cycles(30);
    chk("fill_one_req", rise_cnt, 1);
    chk("fill_req_addr", seen_addr[0], 25'h20);
    chk("fill_refull", fifo_level, 16);

    // frame restart in the middle of a request
    arb_delay = 10;
    pop_expect(16'h5001, "abort_head");
    wait_rd(20, "abort_rd_timeout");
    @(posedge clk);
    pulse_frame(25'h2001, 18'd3);
    arb_delay = 4;
    @(negedge clk);
    chk("abort_rd_drop", vram_rd, 0);
    chk("abort_level", fifo_level, 0);
    chk("abort_valid", pix_valid, 0);
    seen_addr.delete();
    wait_level(3, 200, "abort_timeout");
    chk("abort_new_addr", seen_addr[0], 25'h2000);
    pop_expect(16'h5000, "abort_d0");
    pop_expect(16'h5001, "abort_d1");
    pop_expect(16'h5002, "abort_d2");

    // frame restart on the very cycle a word is accepted
    arb_mode = 1;
    pulse_frame(25'h3000, 18'd2);
    wait_rd(20, "race_rd_timeout");
    @(posedge clk);
    pulse_frame(25'h3000, 18'd0);
    @(negedge clk);
    chk("race_level", fifo_level, 0);
    chk("race_rd", vram_rd, 0);
    idle_cycles(10);
    chk("race_still_empty", fifo_level, 0);
    arb_mode = 0;

    // underflow is sticky until the next frame
    @(posedge clk); #1 pix_pop = 1'b1;
    @(posedge clk); #1 pix_pop = 1'b0;
    idle_cycles(3);
    chk("uf_set", underflow, 1);
    pulse_frame(25'h0, 18'd0);
    @(negedge clk);
    chk("uf_clear", underflow, 0);

    // address wrap at the top of the 25-bit space
    seen_addr.delete();
    pulse_frame(25'h1FFFFFE, 18'd2);
    wait_level(2, 100, "wrap_timeout");
    chk("wrap_a0", seen_addr[0], 25'h1FFFFFE);
    chk("wrap_a1", seen_addr[1], 25'h0);
    pop_expect(16'h5FFF, "wrap_d0");
    pop_expect(16'h5000, "wrap_d1");

    // enable drop does not abort a request and holds off the next
    arb_delay = 6;
    rise_cnt = 0;
    pulse_frame(25'h500, 18'd2);
    wait_rd(20, "en_rd_timeout");
    @(posedge clk); #1 enable = 1'b0;
    idle_cycles(30);
    chk("en_level", fifo_level, 1);
    chk("en_nreq", rise_cnt, 1);
    enable = 1'b1;
    wait_level(2, 100, "en_timeout");
    pop_expect(16'h5280, "en_d0");
    pop_expect(16'h5281, "en_d1");

    // streaming with concurrent pushes and pops
    arb_delay = 2;
    pulse_frame(25'h800, 18'd24);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      pix_pop = (i % 3) != 0;
    end
    pix_pop = 1'b0;

    // reset beats a simultaneous frame_start and an in-flight request
    arb_delay = 10;
    pulse_frame(25'h600, 18'd5);
    wait_rd(20, "rst_rd_timeout");
    @(posedge clk); #1;
    reset = 1'b1; frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    rise_cnt = 0;
    @(negedge clk);
    chk("mid_rst_rd", vram_rd, 0);
    chk("mid_rst_addr", vram_addr, 0);
    chk("mid_rst_level", fifo_level, 0);
    idle_cycles(15);
    chk("mid_rst_no_req", rise_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nubus_vram_fetch.md
NUBUS_VRAM_FETCH -- requirements
Module: nubus_vram_fetch

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, meaning line-buffer depth in 16-bit words (power of 2, 4..64).
REQ-002 SHALL have parameter MIN_REQ, default 3, meaning minimum REQ-state cycles before vram_ready is accepted.
REQ-003 clk  in  1  system clock (clk_sys); the only clock; all logic posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 enable  in  1  high = fetching permitted.
REQ-006 frame_start  in  1  one-cycle pulse; restart the fetch at fb_base.
REQ-007 fb_base  in  25  framebuffer start byte address; bit 0 ignored.
REQ-008 frame_words  in  18  words per frame; 0 = fetch nothing.
REQ-009 vram_addr  out  25  arbiter video-port byte address.
REQ-010 vram_dout  out  16  arbiter write data; constant 0.
REQ-011 vram_rd  out  1  read request to arbiter.
REQ-012 vram_wr  out  1  write request; constant 0.
REQ-013 vram_din  in  16  read data from arbiter.
REQ-014 vram_ready  in  1  arbiter completion indication.
REQ-015 pix_pop  in  1  display shifter consumes the head word.
REQ-016 pix_data  out  16  FIFO head word (first-word fall-through).
REQ-017 pix_valid  out  1  FIFO non-empty.
REQ-018 underflow  out  1  sticky: pop attempted while empty.
REQ-019 fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-020 FSM states SHALL be IDLE, REQ and GAP; vram_rd SHALL be 1 exactly in REQ.
REQ-021 IDLE->REQ SHALL occur when enable=1, remaining>0 and fifo_level<FIFO_DEPTH; vram_addr SHALL be registered and stable throughout REQ.
REQ-022 In REQ, req_age SHALL count from 1 on entry, saturating at MIN_REQ; vram_ready SHALL be ignored while req_age<MIN_REQ (masks stale ready from a previous grant).
REQ-023 REQ->GAP SHALL occur on the cycle vram_ready=1 with req_age>=MIN_REQ; that cycle vram_din SHALL be pushed, vram_addr += 2 (wraps modulo 2^25), remaining -= 1.
REQ-024 GAP SHALL last exactly one cycle and then go to IDLE; vram_ready SHALL be ignored in GAP and IDLE.
REQ-025 enable falling during REQ SHALL NOT abort the request; no new request SHALL issue while enable=0.
REQ-026 At most one request SHALL be outstanding; fifo_level plus outstanding SHALL never exceed FIFO_DEPTH.
REQ-027 frame_start SHALL, next cycle: flush the FIFO (level 0, pix_valid 0), load vram_addr<=fb_base with bit 0 cleared, load remaining<=frame_words, clear underflow, and force GAP from any state with vram_rd=0; data of an aborted REQ SHALL be discarded.
REQ-028 frame_start coinciding with an accepting vram_ready SHALL discard that word; frame_start has priority over every other event.
REQ-029 When remaining=0 the FSM SHALL stay in IDLE until frame_start.
REQ-030 pix_pop with pix_valid=1 SHALL advance the head next cycle; simultaneous push and pop SHALL leave fifo_level unchanged and keep order.
REQ-031 pix_pop with pix_valid=0 SHALL set underflow and change nothing else; a push in that cycle SHALL still be stored.
REQ-032 pix_data SHALL be 16'h0000 when pix_valid=0.
REQ-033 The FIFO SHALL preserve word order; push to a full FIFO SHALL be impossible by REQ-026.

Reset
REQ-034 reset SHALL put the FSM in IDLE, vram_rd=0, vram_addr=0, remaining=0, FIFO empty, pix_valid=0, pix_data=0, underflow=0, fifo_level=0.
REQ-035 reset SHALL dominate frame_start and every in-flight transfer; no request issues until frame_start after reset.

Verification
REQ-036 fb_base=0x100, frame_words=4, enable=1, arbiter ready 4 cycles after grant -> vram_addr 0x100,0x102,0x104,0x106; 4 words in order; then IDLE with vram_rd=0.
REQ-037 vram_ready held high before and at REQ entry -> no capture until req_age=3; captured word equals vram_din on that cycle.
REQ-038 frame_words=40, no pops -> fifo_level reaches 16, vram_rd stays 0; one pop -> exactly one new request issued.
REQ-039 frame_start mid-REQ with fb_base=0x2000 -> vram_rd drops next cycle, FIFO empty, the next request is at 0x2000, the aborted word is never visible.
REQ-040 pix_pop while empty -> underflow=1 and held; next frame_start -> underflow=0.
REQ-041 fb_base=0x1FFFFFE, frame_words=2 -> addresses 0x1FFFFFE then 0x0000000.
